div_const_pipe: RTL and testbench

//  Pipelined unsigned divider by a compile-time constant, generalising the fixed 16/5 combinational divider.

---
 rtl/div_const_pipe_if.sv | 26 ++
 rtl/div_const_pipe.sv | 102 ++++++++++
 tb/tb_div_const_pipe.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_const_pipe_if.sv
// Stream bundle for the constant divider: dividend channel in, quotient/remainder channel out.
// A transfer happens on a rising edge when valid && ready; valid never depends on ready.
interface div_const_pipe_if #(
  parameter int WIDTH   = 16,
  parameter int DIVISOR = 5
);
  localparam int RW = ($clog2(DIVISOR) < 1) ? 1 : $clog2(DIVISOR);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic [RW-1:0]    out_r;

  modport master (
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_q, out_r
  );

  modport slave (
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_q, out_r
  );
endinterface

// File: rtl/div_const_pipe.sv
// Pipelined unsigned divide-by-constant using radix-2^CHUNK digit recurrence,
// one register stage per dividend digit, most significant digit first.
module div_const_pipe #(
  parameter int WIDTH   = 16,
  parameter int DIVISOR = 5,
  parameter int CHUNK   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  div_const_pipe_if.slave bus,
  output logic           busy
);
  localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = STAGES * CHUNK;
  localparam int RW     = ($clog2(DIVISOR) < 1) ? 1 : $clog2(DIVISOR);
  localparam int TW     = RW + CHUNK;

  generate
    if (DIVISOR < 2 || CHUNK < 1 || CHUNK > 8 || WIDTH < 2) begin : g_bad_param
      $error("div_const_pipe: illegal parameter set");
    end
  endgenerate

  // t = r_in*2^CHUNK + d is always below DIVISOR*2^CHUNK, so subtracting the
  // shifted constant once per quotient bit yields the digit; no general divider.
  function automatic logic [TW-1:0] digit_div(input logic [TW-1:0] t);
    logic [TW-1:0]    acc;
    logic [CHUNK-1:0] q;
    acc = t;
    q   = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (acc >= (TW'(DIVISOR) << i)) begin
        acc  = acc - (TW'(DIVISOR) << i);
        q[i] = 1'b1;
      end
    end
    return {q, RW'(acc)};
  endfunction

  // Per-stage state. work_q holds the unprocessed dividend digits in its upper
  // part and the quotient digits produced so far shifted in at the bottom.
  logic [STAGES-1:0] vld_q;
  logic [RW-1:0]     rem_q  [STAGES];
  logic [PW-1:0]     work_q [STAGES];

  logic [STAGES:0]   load;
  logic [STAGES-1:0] vld_in;
  logic [TW-1:0]     qr_d   [STAGES];
  logic [PW-1:0]     work_d [STAGES];
  logic [PW-1:0]     x_ext;

  assign x_ext = PW'(bus.in_x);

  always_comb begin
    load   = '0;
    vld_in = '0;
    qr_d   = '{default: '0};
    work_d = '{default: '0};

    // A stage loads when it is empty or its successor loads this cycle.
    load[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = !vld_q[k] || load[k+1];
    end

    vld_in[0] = bus.in_valid;
    qr_d[0]   = digit_div({{RW{1'b0}}, x_ext[PW-1 -: CHUNK]});
    work_d[0] = (x_ext << CHUNK) | PW'(qr_d[0][RW +: CHUNK]);
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k] = vld_q[k-1];
      qr_d[k]   = digit_div({rem_q[k-1], work_q[k-1][PW-1 -: CHUNK]});
      work_d[k] = (work_q[k-1] << CHUNK) | PW'(qr_d[k][RW +: CHUNK]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        rem_q[k]  <= '0;
        work_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          vld_q[k] <= vld_in[k];
        end
        // Data only moves with a valid item so idle outputs keep their last value.
        if (load[k] && vld_in[k]) begin
          rem_q[k]  <= qr_d[k][RW-1:0];
          work_q[k] <= work_d[k];
        end
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_q     = work_q[STAGES-1][WIDTH-1:0];
  assign bus.out_r     = rem_q[STAGES-1];
  assign busy          = |vld_q;
endmodule

// File: tb/tb_div_const_pipe.sv
// Directed and randomised checks of div_const_pipe at the default and three swept parameter sets.
module tb_div_const_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  div_const_pipe_if #(.WIDTH(16), .DIVISOR(5))  b0 ();
  div_const_pipe_if #(.WIDTH(13), .DIVISOR(7))  b1 ();
  div_const_pipe_if #(.WIDTH(32), .DIVISOR(10)) b2 ();
  div_const_pipe_if #(.WIDTH(8),  .DIVISOR(3))  b3 ();
  logic busy0, busy1, busy2, busy3;

  div_const_pipe #(.WIDTH(16), .DIVISOR(5),  .CHUNK(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0), .busy(busy0));
  div_const_pipe #(.WIDTH(13), .DIVISOR(7),  .CHUNK(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1), .busy(busy1));
  div_const_pipe #(.WIDTH(32), .DIVISOR(10), .CHUNK(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2), .busy(busy2));
  div_const_pipe #(.WIDTH(8),  .DIVISOR(3),  .CHUNK(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3), .busy(busy3));

  logic [15:0] in_q [$];
  logic [18:0] exp_q[$];
  logic [15:0] e1_q [$];
  logic [35:0] e2_q [$];
  logic [9:0]  e3_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [15:0] x, input logic [15:0] q, input logic [2:0] r);
    in_q.push_back(x);
    exp_q.push_back({q, r});
  endtask

  // Drives in_q into dut0 and checks results in order. out_ready is held low for
  // the first 'hold' cycles, then high with probability pct percent.
  task automatic run0(input int hold, input int pct, input int budget,
                      output int acc_hold, output logic rdy_hold, output int gaps);
    int          cyc;
    bit          started;
    bit          frz;
    logic [18:0] e;
    logic [15:0] frz_q;
    cyc = 0; started = 0; frz = 0; frz_q = '0;
    acc_hold = 0; rdy_hold = 1'b1; gaps = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      b0.out_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < pct);
      b0.in_valid  = (in_q.size() != 0);
      b0.in_x      = (in_q.size() != 0) ? in_q[0] : 16'd0;
      #1;
      if (b0.out_valid && b0.out_ready) begin
        e = exp_q.pop_front();
        chk("quotient", b0.out_q, e[18:3]);
        chk("remainder", b0.out_r, e[2:0]);
        started = 1;
      end else if (started && !b0.out_valid) begin
        gaps++;
      end
      if (cyc < hold && b0.out_valid) begin
        if (frz) chk("frozen out_q", b0.out_q, frz_q);
        frz   = 1;
        frz_q = b0.out_q;
      end
      if (b0.in_valid && b0.in_ready) begin
        void'(in_q.pop_front());
        if (cyc < hold) acc_hold++;
      end
      if (cyc == hold - 1) rdy_hold = b0.in_ready;
      cyc++;
      @(negedge clk);
    end
    chk("stream drained", exp_q.size(), 0);
    b0.in_valid  = 1'b0;
    b0.out_ready = 1'b1;
    in_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int          acc;
    logic        rdy;
    int          gaps;
    int          stale;
    logic [15:0] x;
    logic [12:0] x1;
    logic [31:0] x2;
    logic [7:0]  x3;
    logic [15:0] e1;
    logic [35:0] e2;
    logic [9:0]  e3;

    rst_n = 1'b0;
    b0.in_valid = 0; b0.in_x = '0; b0.out_ready = 1;
    b1.in_valid = 0; b1.in_x = '0; b1.out_ready = 1;
    b2.in_valid = 0; b2.in_x = '0; b2.out_ready = 1;
    b3.in_valid = 0; b3.in_x = '0; b3.out_ready = 1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("reset out_valid", b0.out_valid, 0);
    chk("reset busy", busy0, 0);
    chk("reset out_q", b0.out_q, 0);
    chk("reset out_r", b0.out_r, 0);
    chk("reset in_ready", b0.in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Latency: single item, result visible after the fourth edge, one cycle wide
    b0.in_valid = 1; b0.in_x = 16'd1000; b0.out_ready = 1;
    #1;
    chk("lat in_ready", b0.in_ready, 1);
    @(negedge clk);
    b0.in_valid = 0;
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) @(negedge clk);
      chk("lat out_valid", b0.out_valid, (i == 4));
      if (i == 4) begin
        chk("lat out_q", b0.out_q, 200);
        chk("lat out_r", b0.out_r, 0);
      end
    end
    chk("idle hold out_q", b0.out_q, 200);
    chk("idle busy", busy0, 0);
    @(negedge clk);

    // Directed values
    push0(16'd65535, 16'd13107, 3'd0);
    push0(16'd12346, 16'd2469,  3'd1);
    push0(16'd4,     16'd0,     3'd4);
    push0(16'd0,     16'd0,     3'd0);
    run0(0, 100, 50, acc, rdy, gaps);
    chk("directed gaps", gaps, 0);

    // Backpressure: 0..9 with six stalled cycles
    for (int i = 0; i < 10; i++) push0(16'(i), 16'(i / 5), 3'(i % 5));
    run0(6, 100, 100, acc, rdy, gaps);
    chk("bp accepts while stalled", acc, 4);
    chk("bp in_ready low when full", rdy, 0);
    chk("bp gaps after release", gaps, 0);

    // Random full-rate stream with 70% consumer readiness
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      push0(x, x / 16'd5, 3'(x % 16'd5));
    end
    run0(0, 70, 5000, acc, rdy, gaps);

    // Reset with three items in flight
    b0.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      b0.in_valid = 1; b0.in_x = 16'(100 + i);
      @(negedge clk);
    end
    b0.in_valid = 0;
    #1;
    chk("inflight busy", busy0, 1);
    chk("inflight out_valid", b0.out_valid, 0);
    rst_n = 1'b0;
    #1;
    chk("mid-reset out_valid", b0.out_valid, 0);
    chk("mid-reset busy", busy0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b0.out_valid) stale++;
    end
    chk("no stale result", stale, 0);

    // Parameter sweep: 13/7/3 and 32/10/8 random, 8/3/1 exhaustive
    for (int c = 0; c < 256 + 16; c++) begin
      x1 = (c == 0) ? 13'd8191 : 13'($urandom);
      x2 = (c == 0) ? 32'hFFFF_FFFF : $urandom;
      x3 = 8'(c);
      b1.in_valid = (c < 256); b1.in_x = x1;
      b2.in_valid = (c < 256); b2.in_x = x2;
      b3.in_valid = (c < 256); b3.in_x = x3;
      #1;
      if (b1.in_valid && b1.in_ready)
        e1_q.push_back((c == 0) ? {13'd1170, 3'd1} : {x1 / 13'd7, 3'(x1 % 13'd7)});
      if (b2.in_valid && b2.in_ready)
        e2_q.push_back((c == 0) ? {32'd429496729, 4'd5} : {x2 / 32'd10, 4'(x2 % 32'd10)});
      if (b3.in_valid && b3.in_ready)
        e3_q.push_back({x3 / 8'd3, 2'(x3 % 8'd3)});
      if (b1.out_valid) begin
        if (e1_q.size() == 0) chk("w13 extra result", 1, 0);
        else begin
          e1 = e1_q.pop_front();
          chk("w13 quotient", b1.out_q, e1[15:3]);
          chk("w13 remainder", b1.out_r, e1[2:0]);
        end
      end
      if (b2.out_valid) begin
        if (e2_q.size() == 0) chk("w32 extra result", 1, 0);
        else begin
          e2 = e2_q.pop_front();
          chk("w32 quotient", b2.out_q, e2[35:4]);
          chk("w32 remainder", b2.out_r, e2[3:0]);
        end
      end
      if (b3.out_valid) begin
        if (e3_q.size() == 0) chk("w8 extra result", 1, 0);
        else begin
          e3 = e3_q.pop_front();
          chk("w8 quotient", b3.out_q, e3[9:2]);
          chk("w8 remainder", b3.out_r, e3[1:0]);
        end
      end
      @(negedge clk);
    end
    chk("w13 drained", e1_q.size(), 0);
    chk("w32 drained", e2_q.size(), 0);
    chk("w8 drained", e3_q.size(), 0);
    chk("sweep idle busy", {busy1, busy2, busy3}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
